fb_write_sched: RTL and testbench



---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_rr_arb2.sv | 22 ++
 rtl/fb_write_sched.sv | 215 +++++++++++++++++++++
 tb/tb_fb_write_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the framebuffer write scheduler.
package fb_pkg;

    localparam int FB_VIRT_W    = 160;
    localparam int FB_VIRT_H    = 120;
    localparam int FB_MEM_WORDS = FB_VIRT_W * FB_VIRT_H;
    localparam int FB_RGB_W     = 24;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CLEAR     = 2'd1,
        S_SWAP_WAIT = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin arbiter; lg is the last winner, so ~lg wins a tie.
module fb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       lg,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       lg_nxt
);

    logic win;

    always_comb begin
        gnt    = 2'b00;
        lg_nxt = lg;
        win    = (req == 2'b11) ? ~lg : req[1];
        if (en && (req != 2'b00)) begin
            gnt    = win ? 2'b10 : 2'b01;
            lg_nxt = win;
        end
    end

endmodule

// File: rtl/fb_write_sched.sv
// Back-buffer write scheduler: pixel arbitration, frame-aligned swap, optional
// full-buffer clear built only when FB_CLEAR_EN is defined.
module fb_write_sched
    import fb_pkg::*;
#(
    parameter int VIRT_W    = FB_VIRT_W,
    parameter int VIRT_H    = FB_VIRT_H,
    parameter int MEM_WORDS = FB_MEM_WORDS,
    parameter int ADDR_W    = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_done,
    input  logic [1:0]          req,
    input  logic [7:0]          px_x0,
    input  logic [7:0]          px_x1,
    input  logic [6:0]          px_y0,
    input  logic [6:0]          px_y1,
    input  logic [FB_RGB_W-1:0] px_rgb0,
    input  logic [FB_RGB_W-1:0] px_rgb1,
    output logic [1:0]          gnt,
    output logic                oob_err,
    input  logic                clear_start,
    input  logic [FB_RGB_W-1:0] clear_rgb,
    output logic                clear_done,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                back_sel,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [FB_RGB_W-1:0] wr_data,
    output logic                wr_en,
    output logic                busy
);

    localparam logic [7:0]        X_LIM = 8'(VIRT_W);
    localparam logic [6:0]        Y_LIM = 7'(VIRT_H);
    localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(VIRT_H);

    fb_state_e state_q, state_d;
    logic      frame_done_q, fd_rise;
    logic      lg_q, lg_d;
    logic      go_clear, arb_en;
    logic [1:0] arb_gnt;

    logic [1:0]          gnt_q, gnt_d;
    logic                oob_q, oob_d;
    logic                clear_done_q, clear_done_d;
    logic                swap_ack_q, swap_ack_d;
    logic                back_sel_q, back_sel_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [FB_RGB_W-1:0] wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;

    logic [7:0]          sel_x;
    logic [6:0]          sel_y;
    logic [FB_RGB_W-1:0] sel_rgb;
    logic                in_range;
    logic [ADDR_W-1:0]   px_addr;

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(MEM_WORDS);
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [FB_RGB_W-1:0] clr_rgb_q, clr_rgb_d;
    assign go_clear = clear_start;
`else
    logic unused_clr;
    assign unused_clr = ^{clear_start, clear_rgb, MEM_WORDS[0]};
    assign go_clear   = 1'b0;
`endif

    assign fd_rise = frame_done & ~frame_done_q;
    // Pixels only compete when nothing of higher priority is starting this cycle.
    assign arb_en  = (state_q == S_IDLE) & ~go_clear & ~swap_req;

    fb_rr_arb2 u_arb (
        .req    (req),
        .lg     (lg_q),
        .en     (arb_en),
        .gnt    (arb_gnt),
        .lg_nxt (lg_d)
    );

    assign sel_x    = arb_gnt[1] ? px_x1   : px_x0;
    assign sel_y    = arb_gnt[1] ? px_y1   : px_y0;
    assign sel_rgb  = arb_gnt[1] ? px_rgb1 : px_rgb0;
    assign in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);
    assign px_addr  = ADDR_W'(sel_x) * H_A + ADDR_W'(sel_y);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go_clear)      state_d = S_CLEAR;
                else if (swap_req) state_d = S_SWAP_WAIT;
            end
`ifdef FB_CLEAR_EN
            S_CLEAR:     if (clr_cnt_q == WORDS_A) state_d = S_IDLE;
`endif
            S_SWAP_WAIT: if (fd_rise) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d        = 2'b00;
        oob_d        = 1'b0;
        clear_done_d = 1'b0;
        swap_ack_d   = 1'b0;
        back_sel_d   = back_sel_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        busy_d       = (state_d != S_IDLE);
`ifdef FB_CLEAR_EN
        clr_cnt_d    = clr_cnt_q;
        clr_rgb_d    = clr_rgb_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef FB_CLEAR_EN
                if (go_clear) begin
                    wr_addr_d = '0;
                    wr_data_d = clear_rgb;
                    wr_en_d   = 1'b1;
                    clr_rgb_d = clear_rgb;
                    clr_cnt_d = ADDR_W'(1);
                end else
`endif
                if (arb_gnt != 2'b00) begin
                    gnt_d = arb_gnt;
                    if (in_range) begin
                        wr_addr_d = px_addr;
                        wr_data_d = sel_rgb;
                        wr_en_d   = 1'b1;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
            end
`ifdef FB_CLEAR_EN
            // clr_cnt_q is the next word to write; reaching MEM_WORDS means done.
            S_CLEAR: begin
                if (clr_cnt_q == WORDS_A) begin
                    clear_done_d = 1'b1;
                end else begin
                    wr_addr_d = clr_cnt_q;
                    wr_data_d = clr_rgb_q;
                    wr_en_d   = 1'b1;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
`endif
            S_SWAP_WAIT: begin
                if (fd_rise) begin
                    back_sel_d = ~back_sel_q;
                    swap_ack_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done_q <= 1'b0;
            lg_q         <= 1'b1;
            gnt_q        <= 2'b00;
            oob_q        <= 1'b0;
            clear_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            back_sel_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
`ifdef FB_CLEAR_EN
            clr_cnt_q    <= '0;
            clr_rgb_q    <= '0;
`endif
        end else begin
            frame_done_q <= frame_done;
            lg_q         <= lg_d;
            gnt_q        <= gnt_d;
            oob_q        <= oob_d;
            clear_done_q <= clear_done_d;
            swap_ack_q   <= swap_ack_d;
            back_sel_q   <= back_sel_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
`ifdef FB_CLEAR_EN
            clr_cnt_q    <= clr_cnt_d;
            clr_rgb_q    <= clr_rgb_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign oob_err    = oob_q;
    assign clear_done = clear_done_q;
    assign swap_ack   = swap_ack_q;
    assign back_sel   = back_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched: pixel vector table with scoreboard, then swap,
// clear (or clear-disabled) and mid-operation reset sequences.
module tb_fb_write_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_done;
    logic [1:0]  req;
    logic [7:0]  px_x0, px_x1;
    logic [6:0]  px_y0, px_y1;
    logic [23:0] px_rgb0, px_rgb1;
    logic [1:0]  gnt;
    logic        oob_err;
    logic        clear_start;
    logic [23:0] clear_rgb;
    logic        clear_done;
    logic        swap_req;
    logic        swap_ack;
    logic        back_sel;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_en;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fb_write_sched dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .req(req),
        .px_x0(px_x0), .px_x1(px_x1), .px_y0(px_y0), .px_y1(px_y1),
        .px_rgb0(px_rgb0), .px_rgb1(px_rgb1), .gnt(gnt), .oob_err(oob_err),
        .clear_start(clear_start), .clear_rgb(clear_rgb), .clear_done(clear_done),
        .swap_req(swap_req), .swap_ack(swap_ack), .back_sel(back_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy)
    );

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  x0; logic [6:0] y0; logic [23:0] c0;
        logic [7:0]  x1; logic [6:0] y1; logic [23:0] c1;
        logic [1:0]  gnt; logic oob; logic en;
        logic [14:0] addr; logic [23:0] data;
    } vec_t;

    typedef struct {
        logic [1:0]  gnt; logic oob; logic en;
        logic [14:0] addr; logic [23:0] data;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 0);
        chk({nm, "_oob"}, 32'(oob_err), 0);
        chk({nm, "_cdone"}, 32'(clear_done), 0);
        chk({nm, "_sack"}, 32'(swap_ack), 0);
        chk({nm, "_bsel"}, 32'(back_sel), 0);
        chk({nm, "_addr"}, 32'(wr_addr), 0);
        chk({nm, "_data"}, 32'(wr_data), 0);
        chk({nm, "_wen"}, 32'(wr_en), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        exp_t e;
        int   bad;

        vecs[0]  = '{2'b11, 8'd3,   7'd5,   24'h111111, 8'd1,  7'd1,   24'h222222, 2'b01, 1'b0, 1'b1, 15'd365,   24'h111111};
        vecs[1]  = '{2'b11, 8'd3,   7'd5,   24'h111111, 8'd1,  7'd1,   24'h222222, 2'b10, 1'b0, 1'b1, 15'd121,   24'h222222};
        vecs[2]  = '{2'b11, 8'd3,   7'd5,   24'h111111, 8'd1,  7'd1,   24'h222222, 2'b01, 1'b0, 1'b1, 15'd365,   24'h111111};
        vecs[3]  = '{2'b11, 8'd3,   7'd5,   24'h111111, 8'd1,  7'd1,   24'h222222, 2'b10, 1'b0, 1'b1, 15'd121,   24'h222222};
        vecs[4]  = '{2'b00, 8'd0,   7'd0,   24'h0,      8'd0,  7'd0,   24'h0,      2'b00, 1'b0, 1'b0, 15'd0,     24'h0};
        vecs[5]  = '{2'b01, 8'd159, 7'd119, 24'hABCDEF, 8'd0,  7'd0,   24'h0,      2'b01, 1'b0, 1'b1, 15'd19199, 24'hABCDEF};
        vecs[6]  = '{2'b10, 8'd0,   7'd0,   24'h0,      8'd0,  7'd0,   24'h000001, 2'b10, 1'b0, 1'b1, 15'd0,     24'h000001};
        vecs[7]  = '{2'b01, 8'd160, 7'd0,   24'h123456, 8'd0,  7'd0,   24'h0,      2'b01, 1'b1, 1'b0, 15'd0,     24'h0};
        vecs[8]  = '{2'b10, 8'd0,   7'd0,   24'h0,      8'd0,  7'd120, 24'h654321, 2'b10, 1'b1, 1'b0, 15'd0,     24'h0};
        vecs[9]  = '{2'b10, 8'd0,   7'd0,   24'h0,      8'd0,  7'd119, 24'h0000FF, 2'b10, 1'b0, 1'b1, 15'd119,   24'h0000FF};
        vecs[10] = '{2'b11, 8'd10,  7'd10,  24'hAAAAAA, 8'd20, 7'd20,  24'hBBBBBB, 2'b01, 1'b0, 1'b1, 15'd1210,  24'hAAAAAA};
        vecs[11] = '{2'b01, 8'd255, 7'd127, 24'hCCCCCC, 8'd0,  7'd0,   24'h0,      2'b01, 1'b1, 1'b0, 15'd0,     24'h0};
        vecs[12] = '{2'b11, 8'd2,   7'd0,   24'hDDDDDD, 8'd0,  7'd2,   24'hEEEEEE, 2'b10, 1'b0, 1'b1, 15'd2,     24'hEEEEEE};

        // Reset with busy-looking inputs applied
        rst = 1'b0; frame_done = 1'b0; req = 2'b11;
        px_x0 = 8'd1; px_y0 = 7'd1; px_rgb0 = 24'h1; px_x1 = 8'd2; px_y1 = 7'd2; px_rgb1 = 24'h2;
        clear_start = 1'b1; clear_rgb = 24'hFFFFFF; swap_req = 1'b1;
        repeat (3) step();
        chk_all_zero("rst_held");
        req = 2'b00; clear_start = 1'b0; swap_req = 1'b0;
        rst = 1'b1;
        step();
        chk_all_zero("rst_rel");

        for (int i = 0; i < 13; i++) begin
            req = vecs[i].req;
            px_x0 = vecs[i].x0; px_y0 = vecs[i].y0; px_rgb0 = vecs[i].c0;
            px_x1 = vecs[i].x1; px_y1 = vecs[i].y1; px_rgb1 = vecs[i].c1;
            sb.push_back('{vecs[i].gnt, vecs[i].oob, vecs[i].en, vecs[i].addr, vecs[i].data});
            step();
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_empty: got none expected entry for vec %0d", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(e.gnt));
                chk($sformatf("v%0d_oob", i), 32'(oob_err), 32'(e.oob));
                chk($sformatf("v%0d_wen", i), 32'(wr_en), 32'(e.en));
                if (e.en) begin
                    chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(e.addr));
                    chk($sformatf("v%0d_data", i), 32'(wr_data), 32'(e.data));
                end
            end
        end
        req = 2'b00;
        step();

        // Late swap request during blank must wait for the next rising edge
        frame_done = 1'b1;
        step();
        swap_req = 1'b1; req = 2'b01; px_x0 = 8'd1; px_y0 = 7'd1; px_rgb0 = 24'h5;
        step();
        chk("sw1_busy", 32'(busy), 1);
        chk("sw1_nogrant", 32'(gnt), 0);
        swap_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sw1_hold_ack", 32'(swap_ack), 0);
            chk("sw1_hold_gnt", 32'(gnt), 0);
            chk("sw1_hold_bsel", 32'(back_sel), 0);
        end
        frame_done = 1'b0;
        step(); chk("sw1_low_ack", 32'(swap_ack), 0);
        step(); chk("sw1_low_ack2", 32'(swap_ack), 0);
        frame_done = 1'b1;
        step();
        chk("sw1_ack", 32'(swap_ack), 1);
        chk("sw1_bsel", 32'(back_sel), 1);
        chk("sw1_busy_off", 32'(busy), 0);
        step();
        chk("sw1_ack_pulse", 32'(swap_ack), 0);
        chk("sw1_gnt_after", 32'(gnt), 1);
        req = 2'b00;
        step();

        // Second swap flips back; clear_start during the wait is ignored
        frame_done = 1'b0; swap_req = 1'b1;
        step();
        chk("sw2_busy", 32'(busy), 1);
        swap_req = 1'b0; clear_start = 1'b1; clear_rgb = 24'h0F0F0F;
        step();
        chk("sw2_clr_ign", 32'(wr_en), 0);
        clear_start = 1'b0; frame_done = 1'b1;
        step();
        chk("sw2_ack", 32'(swap_ack), 1);
        chk("sw2_bsel", 32'(back_sel), 0);
        step();
        chk("sw2_no_wr", 32'(wr_en), 0);
        chk("sw2_idle", 32'(busy), 0);
        frame_done = 1'b0;
        step();

`ifdef FB_CLEAR_EN
        // Full clear with requester 0 waiting throughout
        req = 2'b01; px_x0 = 8'd1; px_y0 = 7'd2; px_rgb0 = 24'h0000AA;
        clear_start = 1'b1; clear_rgb = 24'hFF0000;
        bad = 0;
        for (int k = 0; k < 19200; k++) begin
            step();
            if (!(wr_en === 1'b1 && wr_addr === 15'(k) && wr_data === 24'hFF0000 &&
                  gnt === 2'b00 && busy === 1'b1 && clear_done === 1'b0)) bad++;
            if (k == 0) begin clear_start = 1'b0; clear_rgb = 24'h00FF00; end
            if (k == 50) swap_req = 1'b1;
            if (k == 51) swap_req = 1'b0;
        end
        chk("clr_words_bad", 32'(bad), 0);
        step();
        chk("clr_done", 32'(clear_done), 1);
        chk("clr_busy_off", 32'(busy), 0);
        chk("clr_wen_off", 32'(wr_en), 0);
        step();
        chk("clr_done_pulse", 32'(clear_done), 0);
        chk("clr_gnt_after", 32'(gnt), 1);
        chk("clr_px_addr", 32'(wr_addr), 122);
        chk("clr_px_data", 32'(wr_data), 32'h0000AA);
        req = 2'b00;
        step();

        // Reset in cycle 100 of a clear
        clear_start = 1'b1; clear_rgb = 24'h123456;
        step();
        clear_start = 1'b0;
        repeat (99) step();
        chk("rclr_active", 32'(wr_en), 1);
        rst = 1'b0;
        #1;
        chk_all_zero("rclr");
        step();
        rst = 1'b1;
        step();
        chk("rclr_no_resume", 32'(wr_en), 0);
        chk("rclr_no_busy", 32'(busy), 0);
`else
        clear_start = 1'b1; clear_rgb = 24'hFF0000;
        step();
        chk("noclr_wen", 32'(wr_en), 0);
        chk("noclr_busy", 32'(busy), 0);
        chk("noclr_done", 32'(clear_done), 0);
        clear_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("noclr_wen_h", 32'(wr_en), 0);
            chk("noclr_done_h", 32'(clear_done), 0);
        end
`endif

        // Reset during swap-wait discards the pending swap
        frame_done = 1'b0; swap_req = 1'b1;
        step();
        swap_req = 1'b0; frame_done = 1'b1;
        step();
        chk("rsw_pre_bsel", 32'(back_sel), 1);
        frame_done = 1'b0; swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        chk("rsw_waiting", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk_all_zero("rsw");
        step();
        rst = 1'b1;
        frame_done = 1'b1;
        step();
        chk("rsw_no_ack", 32'(swap_ack), 0);
        chk("rsw_bsel", 32'(back_sel), 0);
        chk("rsw_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
